// File: rtl/trig_pll_pkg.sv
// Shared types and defaults for the trigger-PLL lock supervisor.
// Holds the FSM state encoding and the helpers used to size the shared down-counter.
package trig_pll_pkg;

    typedef enum logic [1:0] {
        PLL_RST   = 2'd0,
        WAIT_LOCK = 2'd1,
        SETTLE    = 2'd2,
        RUN       = 2'd3
    } pll_state_t;

    localparam int DEF_RST_CYCLES    = 16;
    localparam int DEF_LOCK_TIMEOUT  = 65535;
    localparam int DEF_SETTLE_CYCLES = 1024;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

    // Counter only ever holds load values N-1, so clog2(N) bits suffice; never narrower than 1.
    function automatic int cnt_width(input int max_val);
        return (max_val > 1) ? $clog2(max_val) : 1;
    endfunction

endpackage

// File: rtl/ff_sync.sv
// Two-stage flop synchronizer for bringing asynchronous levels into the i_clk domain.
// Both stages clear to 0 on i_reset_n.
module ff_sync #(
    parameter int WIDTH = 1
) (
    input  logic             i_clk,
    input  logic             i_reset_n,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] meta_reg;
    logic [WIDTH-1:0] sync_reg;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            meta_reg <= '0;
            sync_reg <= '0;
        end else begin
            meta_reg <= i_d;
            sync_reg <= meta_reg;
        end
    end

    assign o_q = sync_reg;

endmodule

// File: rtl/trig_pll_lock_monitor.sv
// Supervises the trigger PLL: holds it in reset, waits for a settled lock, releases
// downstream logic, and re-arms the PLL on lock loss, timeout or explicit request.
module trig_pll_lock_monitor
    import trig_pll_pkg::*;
#(
    parameter int RST_CYCLES    = DEF_RST_CYCLES,
    parameter int LOCK_TIMEOUT  = DEF_LOCK_TIMEOUT,
    parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES,
    parameter int CNT_W         = 16
) (
    input  logic             i_clk,
    input  logic             i_reset_n,
    input  logic             i_locked,
    input  logic             i_rearm,
    output logic             o_pll_rst,
    output logic             o_ready,
    output logic [1:0]       o_state,
    output logic [CNT_W-1:0] o_loss_cnt,
    output logic [CNT_W-1:0] o_timeout_cnt
);

    localparam int TMR_W = cnt_width(max3(RST_CYCLES, LOCK_TIMEOUT, SETTLE_CYCLES));

    localparam logic [TMR_W-1:0] RST_LOAD    = TMR_W'(RST_CYCLES - 1);
    localparam logic [TMR_W-1:0] TMO_LOAD    = TMR_W'(LOCK_TIMEOUT - 1);
    localparam logic [TMR_W-1:0] SETTLE_LOAD = TMR_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_SAT     = '1;

    logic             lock_s;
    pll_state_t       state_reg, state_next;
    logic [TMR_W-1:0] tmr_reg, tmr_next;
    logic [CNT_W-1:0] loss_cnt_reg, loss_cnt_next;
    logic [CNT_W-1:0] timeout_cnt_reg, timeout_cnt_next;
    logic             tmr_zero;

    ff_sync #(
        .WIDTH(1)
    ) u_lock_sync (
        .i_clk     (i_clk),
        .i_reset_n (i_reset_n),
        .i_d       (i_locked),
        .o_q       (lock_s)
    );

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_reg       <= PLL_RST;
            tmr_reg         <= RST_LOAD;
            loss_cnt_reg    <= '0;
            timeout_cnt_reg <= '0;
        end else begin
            state_reg       <= state_next;
            tmr_reg         <= tmr_next;
            loss_cnt_reg    <= loss_cnt_next;
            timeout_cnt_reg <= timeout_cnt_next;
        end
    end

    assign tmr_zero = (tmr_reg == '0);

    always_comb begin
        state_next       = state_reg;
        tmr_next         = tmr_reg;
        loss_cnt_next    = loss_cnt_reg;
        timeout_cnt_next = timeout_cnt_reg;

        // A rearm request overrides everything, including a coincident lock loss.
        if (i_rearm) begin
            state_next = PLL_RST;
            tmr_next   = RST_LOAD;
        end else begin
            case (state_reg)
                PLL_RST: begin
                    if (tmr_zero) begin
                        state_next = WAIT_LOCK;
                        tmr_next   = TMO_LOAD;
                    end else begin
                        tmr_next = tmr_reg - 1'b1;
                    end
                end
                WAIT_LOCK: begin
                    if (lock_s) begin
                        state_next = SETTLE;
                        tmr_next   = SETTLE_LOAD;
                    end else if (tmr_zero) begin
                        state_next = PLL_RST;
                        tmr_next   = RST_LOAD;
                        if (timeout_cnt_reg != CNT_SAT) begin
                            timeout_cnt_next = timeout_cnt_reg + 1'b1;
                        end
                    end else begin
                        tmr_next = tmr_reg - 1'b1;
                    end
                end
                SETTLE: begin
                    // A glitch during settling restarts the lock wait, not the PLL.
                    if (!lock_s) begin
                        state_next = WAIT_LOCK;
                        tmr_next   = TMO_LOAD;
                    end else if (tmr_zero) begin
                        state_next = RUN;
                    end else begin
                        tmr_next = tmr_reg - 1'b1;
                    end
                end
                RUN: begin
                    if (!lock_s) begin
                        state_next = PLL_RST;
                        tmr_next   = RST_LOAD;
                        if (loss_cnt_reg != CNT_SAT) begin
                            loss_cnt_next = loss_cnt_reg + 1'b1;
                        end
                    end
                end
                default: begin
                    state_next = PLL_RST;
                    tmr_next   = RST_LOAD;
                end
            endcase
        end
    end

    assign o_pll_rst     = (state_reg == PLL_RST);
    assign o_ready       = (state_reg == RUN);
    assign o_state       = state_reg;
    assign o_loss_cnt    = loss_cnt_reg;
    assign o_timeout_cnt = timeout_cnt_reg;

endmodule

// File: tb/tb_trig_pll_lock_monitor.sv
// Directed bench for trig_pll_lock_monitor with RST_CYCLES=4, LOCK_TIMEOUT=20, SETTLE_CYCLES=8, CNT_W=4.
// Per-cycle vector tables cover power-up, lock loss and settle glitch; hand sequences cover the rest.
module tb_trig_pll_lock_monitor;

    logic       clk;
    logic       reset_n;
    logic       locked;
    logic       rearm;
    logic       pll_rst;
    logic       ready;
    logic [1:0] state;
    logic [3:0] loss_cnt;
    logic [3:0] timeout_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic       locked;
        logic       rearm;
        logic [1:0] state;
        logic [3:0] loss;
        logic [3:0] tmo;
    } vec_t;

    vec_t vecs[$];

    trig_pll_lock_monitor #(
        .RST_CYCLES    (4),
        .LOCK_TIMEOUT  (20),
        .SETTLE_CYCLES (8),
        .CNT_W         (4)
    ) dut (
        .i_clk         (clk),
        .i_reset_n     (reset_n),
        .i_locked      (locked),
        .i_rearm       (rearm),
        .o_pll_rst     (pll_rst),
        .o_ready       (ready),
        .o_state       (state),
        .o_loss_cnt    (loss_cnt),
        .o_timeout_cnt (timeout_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic add(input int n, input logic lk, input logic ra,
                       input logic [1:0] st, input logic [3:0] ls, input logic [3:0] to);
        vec_t v;
        v.locked = lk; v.rearm = ra; v.state = st; v.loss = ls; v.tmo = to;
        for (int k = 0; k < n; k++) vecs.push_back(v);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, ".pll_rst"}, int'(pll_rst), 1);
        check({tag, ".ready"}, int'(ready), 0);
        check({tag, ".state"}, int'(state), 0);
        check({tag, ".loss"}, int'(loss_cnt), 0);
        check({tag, ".tmo"}, int'(timeout_cnt), 0);
    endtask

    // Assert reset between edges, check outputs with no edge, release just after the next edge.
    task automatic do_reset(input string tag, input logic lk);
        @(posedge clk);
        #2;
        locked  = lk;
        rearm   = 1'b0;
        reset_n = 1'b0;
        #1;
        check_reset_values(tag);
        $display("reset %s: pll_rst=%0b ready=%0b state=%0d", tag, pll_rst, ready, state);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    task automatic run_rows(input string tag, input int lo, input int hi);
        for (int i = lo; i < hi; i++) begin
            locked = vecs[i].locked;
            rearm  = vecs[i].rearm;
            step();
            $display("%s row %0d: locked=%0b rearm=%0b -> state=%0d pll_rst=%0b ready=%0b loss=%0d tmo=%0d",
                     tag, i - lo + 1, locked, rearm, state, pll_rst, ready, loss_cnt, timeout_cnt);
            check($sformatf("%s[%0d].state", tag, i - lo + 1), int'(state), int'(vecs[i].state));
            check($sformatf("%s[%0d].pll_rst", tag, i - lo + 1), int'(pll_rst), int'(vecs[i].state == 2'd0));
            check($sformatf("%s[%0d].ready", tag, i - lo + 1), int'(ready), int'(vecs[i].state == 2'd3));
            check($sformatf("%s[%0d].loss", tag, i - lo + 1), int'(loss_cnt), int'(vecs[i].loss));
            check($sformatf("%s[%0d].tmo", tag, i - lo + 1), int'(timeout_cnt), int'(vecs[i].tmo));
        end
    endtask

    initial begin
        int a_end;
        int b_end;
        int n;
        int exp_tmo;
        bit seen;

        reset_n = 1'b0;
        locked  = 1'b0;
        rearm   = 1'b0;

        // Segment A: power-up with lock 5 cycles after release, then lock loss and re-lock in RUN.
        add(3, 0, 0, 2'd0, 0, 0);
        add(1, 0, 0, 2'd1, 0, 0);
        add(2, 1, 0, 2'd1, 0, 0);
        add(8, 1, 0, 2'd2, 0, 0);
        add(2, 1, 0, 2'd3, 0, 0);
        add(2, 0, 0, 2'd3, 0, 0);
        add(4, 0, 0, 2'd0, 1, 0);
        add(1, 0, 0, 2'd1, 1, 0);
        add(2, 1, 0, 2'd1, 1, 0);
        add(8, 1, 0, 2'd2, 1, 0);
        add(1, 1, 0, 2'd3, 1, 0);
        a_end = vecs.size();
        // Segment B: lock present from release, 3-cycle glitch low during SETTLE.
        add(3, 1, 0, 2'd0, 0, 0);
        add(1, 1, 0, 2'd1, 0, 0);
        add(1, 1, 0, 2'd2, 0, 0);
        add(2, 0, 0, 2'd2, 0, 0);
        add(1, 0, 0, 2'd1, 0, 0);
        add(2, 1, 0, 2'd1, 0, 0);
        add(8, 1, 0, 2'd2, 0, 0);
        add(1, 1, 0, 2'd3, 0, 0);
        b_end = vecs.size();

        do_reset("por", 1'b0);
        run_rows("pwrup", 0, a_end);

        // Rearm in the same cycle the FSM sees lock loss: counts as rearm only.
        locked = 1'b0;
        step();
        check("rearm.pre1_state", int'(state), 3);
        step();
        check("rearm.pre2_ready", int'(ready), 1);
        rearm = 1'b1;
        step();
        rearm = 1'b0;
        $display("rearm+loss: state=%0d pll_rst=%0b loss=%0d", state, pll_rst, loss_cnt);
        check("rearm.state", int'(state), 0);
        check("rearm.pll_rst", int'(pll_rst), 1);
        check("rearm.loss", int'(loss_cnt), 1);

        // Drive into SETTLE, then assert reset asynchronously mid-cycle.
        locked = 1'b1;
        seen = 1'b0;
        n = 0;
        while (!seen && n < 40) begin
            step();
            n++;
            if (state == 2'd2) seen = 1'b1;
        end
        check("settle.reached", int'(seen), 1);
        check("settle.loss_before", int'(loss_cnt), 1);
        #3;
        reset_n = 1'b0;
        #1;
        $display("async reset in SETTLE: state=%0d pll_rst=%0b ready=%0b loss=%0d", state, pll_rst, ready, loss_cnt);
        check_reset_values("async");
        @(posedge clk);
        #1;
        check_reset_values("async_held");
        reset_n = 1'b1;

        // Glitch run needs a clean release; do_reset sets lock high while in reset.
        do_reset("glitch", 1'b1);
        run_rows("glitch", a_end, b_end);

        // Lock never arrives: one timeout per 4+20 cycles, saturating at 15.
        do_reset("tmo", 1'b0);
        for (int c = 1; c <= 24 * 17; c++) begin
            step();
            exp_tmo = (c / 24 > 15) ? 15 : c / 24;
            check($sformatf("tmo.cnt@%0d", c), int'(timeout_cnt), exp_tmo);
            check($sformatf("tmo.ready@%0d", c), int'(ready), 0);
            if (c % 24 == 0)
                $display("timeout cycle %0d: tmo=%0d state=%0d", c, timeout_cnt, state);
        end
        check("tmo.loss", int'(loss_cnt), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
